// File: rtl/uofdm_frame_split.sv
// uofdm_frame_split: buffers one IFFT frame, then emits it as a positive half-frame followed by a flipped-negative half-frame.
module uofdm_frame_split #(
  parameter int N  = 128,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          src_valid,
  input  logic          src_sop,
  input  logic          src_eop,
  input  logic [DW-1:0] src_real,
  output logic          src_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_pos,
  output logic          frame_err
);
  localparam int AW = N > 1 ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, FILL, EMIT_POS, EMIT_NEG} state_t;
  state_t state;
  logic [AW-1:0] widx, ridx;
  logic last_issued;
  logic signed [DW-1:0] mem [N];
  logic signed [DW-1:0] x;
  logic [DW-1:0] pos_val, neg_val;
  logic accept, load, out_fire;
  assign src_ready = reset && (state == IDLE || state == FILL);
  assign accept    = src_valid && src_ready;
  assign out_fire  = out_valid && out_ready;
  // The output register refills whenever it is empty or being drained, giving one beat per clock.
  assign load = (state == EMIT_POS || (state == EMIT_NEG && !last_issued)) && (!out_valid || out_ready);
  assign x    = mem[ridx];
  always_comb begin
    pos_val = x > 0 ? x : '0;
    neg_val = x == SMIN ? SMAX : (x < 0 ? -x : '0);
  end
  always_ff @(posedge clk) begin
    if (accept && (state == FILL || src_sop))
      mem[src_sop ? '0 : widx] <= src_real;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      widx        <= '0;
      ridx        <= '0;
      last_issued <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_pos     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (out_fire)
        out_valid <= 1'b0;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= state == EMIT_POS ? pos_val : neg_val;
        out_sop   <= ridx == '0;
        out_eop   <= ridx == LAST;
        out_pos   <= state == EMIT_POS;
        ridx      <= ridx == LAST ? '0 : ridx + 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept && src_sop) begin
            if (src_eop)
              frame_err <= 1'b1;
            else begin
              state <= FILL;
              widx  <= AW'(1);
            end
          end
        end
        FILL: begin
          if (accept) begin
            if (src_sop) begin
              frame_err <= 1'b1;
              widx      <= AW'(1);
            end else if (widx == LAST) begin
              if (src_eop)
                state <= EMIT_POS;
              else begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end else if (src_eop) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else
              widx <= widx + 1'b1;
          end
        end
        EMIT_POS: begin
          if (load && ridx == LAST)
            state <= EMIT_NEG;
        end
        default: begin
          if (load && ridx == LAST)
            last_issued <= 1'b1;
          // Only the handshake of the final negative beat frees the buffer for the next frame.
          if (out_fire && out_eop && !out_pos) begin
            state       <= IDLE;
            last_issued <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
